dac_sample_out: RTL and testbench
=================================

// Module: dac_sample_out
// PURPOSE
//  Output end of the sample path: accepts processed signed samples from the wavelet
//  pipeline over valid/ready, buffers them in a small FIFO, and drives a DAC_WIDTH-bit
//  offset-binary DAC word, one sample per dac_tick strobe.
//  Saturates wide inputs, primes the FIFO before output starts, and handles underrun.
// PARAMETERS
//  IN_WIDTH    18  width of signed two's-complement input sample
//  DAC_WIDTH   14  width of DAC output word (offset binary)
//  FIFO_DEPTH  16  buffer entries; power of 2, >= 4
//  PRIME_LEVEL 8   entries required before output starts (1..FIFO_DEPTH)
// PORTS
//  clk          in   1                     system clock, all logic on rising edge
//  rst          in   1                     asynchronous reset, active-high
//  s_data       in   IN_WIDTH              signed input sample
//  s_valid      in   1                     s_data valid
//  s_ready      out  1                     block can accept a sample
//  dac_tick     in   1                     one-cycle strobe: DAC consumes a sample
//  dac_out      out  DAC_WIDTH             registered DAC word, offset binary
//  running      out  1                     high while in RUN state
//  sat_pulse    out  1                     1-cycle pulse: accepted sample was clipped
//  underrun     out  1                     1-cycle pulse: tick arrived with FIFO empty
//  fill_level   out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  underrun_cnt out  16                    (only with DAC_UNDERRUN_CNT_EN) underrun count
// BEHAVIOUR
//  Reset: FIFO empty, state PRIME, dac_out=midscale (1<<(DAC_WIDTH-1)),
//   s_ready=1, running=0, sat_pulse=0, underrun=0, fill_level=0, underrun_cnt=0.
//  Push: on s_valid&&s_ready. s_ready = (fill_level<FIFO_DEPTH), combinational from count.
//  Conversion happens at push; the FIFO stores DAC_WIDTH-bit words:
//   clip s_data to [-(2^(DAC_WIDTH-1)), 2^(DAC_WIDTH-1)-1].
//   Clipping asserts sat_pulse in the cycle after the push.
//   Then invert the MSB to convert to offset binary (-8192->0x0000, 0->0x2000, 8191->0x3FFF).
//  FSM states:
//   PRIME: dac_tick ignored; dac_out holds its value.
//    Go to RUN when fill_level >= PRIME_LEVEL, evaluated on the registered count.
//   RUN: on dac_tick with fill_level>0, pop the head.
//    dac_out takes the head word on the next clock edge (1-cycle latency).
//    On dac_tick with fill_level==0: underrun pulse; dac_out holds the last word; go to PRIME.
//  Simultaneous push+pop in one cycle: count unchanged; both succeed.
//  Push in the same cycle as a tick on an empty FIFO: no bypass.
//   The tick is still an underrun.
//   The pushed sample is stored.
//  Full FIFO: s_ready=0, s_valid ignored, no data loss upstream (source must hold).
//  Pointers wrap modulo FIFO_DEPTH. fill_level never exceeds FIFO_DEPTH.
//  End-to-end latency, first push to first dac_out change:
//   PRIME_LEVEL pushes + 1 cycle FSM + first tick + 1 cycle.
//  Reset mid-operation: FIFO contents discarded, all outputs return to reset values at once.
//  dac_tick held high for several cycles counts as one tick per cycle.
// CONFIGURATION
//  DAC_UNDERRUN_CNT_EN defined:
//   underrun_cnt port exists; increments on each underrun pulse.
//   Saturates at 0xFFFF; cleared only by rst.
//  Not defined: port and counter are absent.
//   Underrun signalling is the underrun pulse only.
// TESTING
//  1. Reset, push 8 samples 0..7, then ticks -> running=1.
//     dac_out=0x2000,0x2001..0x2007 one cycle after each tick.
//  2. Push s_data=18'sh1FFFF and 18'sh20000 (IN_WIDTH=18) -> dac_out 0x3FFF then 0x0000.
//     sat_pulse high once per push.
//  3. Push 16 samples with no ticks -> s_ready=0, fill_level=16.
//     A 17th s_valid is not accepted; one tick -> s_ready=1.
//  4. Prime 8 samples, issue 9 ticks -> 9th tick gives underrun pulse.
//     dac_out holds the 8th word; state returns to PRIME (running=0).
//     With DAC_UNDERRUN_CNT_EN, underrun_cnt=1.
//  5. At fill_level=5 in RUN, push and tick in the same cycle -> fill_level stays 5.
//     Output order is preserved.
//  6. Assert rst mid-stream at fill_level=10 -> next cycle dac_out=0x2000, fill_level=0,
//     s_ready=1, running=0.

Source files
------------

// File: rtl/dac_sample_out_if.sv
// Sample stream into the DAC output stage: signed samples over valid/ready.
// A transfer occurs on any rising clk edge where s_valid && s_ready are both high.
// The source holds s_data/s_valid stable until the transfer completes.
// s_ready may change without regard to s_valid.
interface dac_sample_out_if #(
  parameter int IN_WIDTH = 18
);
  logic signed [IN_WIDTH-1:0] s_data;
  logic                       s_valid;
  logic                       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/dac_sample_out.sv
// DAC output stage: saturating signed->offset-binary conversion, priming FIFO, tick-driven output.
// Optional feature: define DAC_UNDERRUN_CNT_EN to add the saturating underrun_cnt port.
module dac_sample_out #(
  parameter int IN_WIDTH    = 18,
  parameter int DAC_WIDTH   = 14,
  parameter int FIFO_DEPTH  = 16,
  parameter int PRIME_LEVEL = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  dac_sample_out_if.slave               s_if,
  input  logic                          dac_tick,
  output logic [DAC_WIDTH-1:0]          dac_out,
  output logic                          running,
  output logic                          sat_pulse,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
`ifdef DAC_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                   underrun_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PRIME_C = CW'(PRIME_LEVEL);

  localparam logic signed [IN_WIDTH-1:0] MAX_IN = IN_WIDTH'(2 ** (DAC_WIDTH - 1) - 1);
  localparam logic signed [IN_WIDTH-1:0] MIN_IN = IN_WIDTH'(-(2 ** (DAC_WIDTH - 1)));
  localparam logic [DAC_WIDTH-1:0]       MIDSCALE = {1'b1, {(DAC_WIDTH - 1){1'b0}}};

  localparam logic [0:0] ST_PRIME = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]           state;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [DAC_WIDTH-1:0] mem [FIFO_DEPTH];

  logic signed [IN_WIDTH-1:0] in_s;
  logic                       clip_hi;
  logic                       clip_lo;
  logic [DAC_WIDTH-1:0]       clipped;
  logic [DAC_WIDTH-1:0]       conv_word;

  logic push;
  logic pop;
  logic underrun_ev;

  assign s_if.s_ready = (count < DEPTH_C);
  assign fill_level   = count;
  assign running      = (state == ST_RUN);

  assign push        = s_if.s_valid && s_if.s_ready;
  assign pop         = (state == ST_RUN) && dac_tick && (count != '0);
  assign underrun_ev = (state == ST_RUN) && dac_tick && (count == '0);

  // Clip to the DAC's signed range, then flipping the MSB yields offset binary.
  always_comb begin
    in_s    = s_if.s_data;
    clip_hi = (in_s > MAX_IN);
    clip_lo = (in_s < MIN_IN);
    if (clip_hi) begin
      clipped = MAX_IN[DAC_WIDTH-1:0];
    end else if (clip_lo) begin
      clipped = MIN_IN[DAC_WIDTH-1:0];
    end else begin
      clipped = in_s[DAC_WIDTH-1:0];
    end
    conv_word = {~clipped[DAC_WIDTH-1], clipped[DAC_WIDTH-2:0]};
  end

  // Storage array carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= conv_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // PRIME waits on the registered count, so RUN starts one cycle after the level is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_PRIME;
    end else begin
      case (state)
        ST_PRIME: if (count >= PRIME_C) state <= ST_RUN;
        ST_RUN:   if (underrun_ev) state <= ST_PRIME;
        default:  state <= ST_PRIME;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dac_out   <= MIDSCALE;
      sat_pulse <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (pop) begin
        dac_out <= mem[rd_ptr];
      end
      sat_pulse <= push && (clip_hi || clip_lo);
      underrun  <= underrun_ev;
    end
  end

`ifdef DAC_UNDERRUN_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_cnt <= '0;
    end else if (underrun_ev && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dac_sample_out.sv
// Bench for dac_sample_out: directed scenarios plus random traffic against a queue-based model.
module tb_dac_sample_out;

  localparam int IW    = 18;
  localparam int DW    = 14;
  localparam int DEPTH = 16;
  localparam int PRIME = 8;

  logic          clk;
  logic          rst;
  logic          dac_tick;
  logic [DW-1:0] dac_out;
  logic          running;
  logic          sat_pulse;
  logic          underrun;
  logic [4:0]    fill_level;
`ifdef DAC_UNDERRUN_CNT_EN
  logic [15:0]   underrun_cnt;
`endif

  dac_sample_out_if #(.IN_WIDTH(IW)) s_if ();

  dac_sample_out #(
    .IN_WIDTH   (IW),
    .DAC_WIDTH  (DW),
    .FIFO_DEPTH (DEPTH),
    .PRIME_LEVEL(PRIME)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_if        (s_if.slave),
    .dac_tick    (dac_tick),
    .dac_out     (dac_out),
    .running     (running),
    .sat_pulse   (sat_pulse),
    .underrun    (underrun),
    .fill_level  (fill_level)
`ifdef DAC_UNDERRUN_CNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: expected FIFO contents plus expected registered outputs
  logic [DW-1:0] exp_q[$];
  logic          m_run;
  logic [DW-1:0] m_dac;
  logic          m_sat;
  logic          m_und;
  int            m_ucnt;
  int            vectors;
  int            miscompares;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_run  = 1'b0;
    m_dac  = 14'h2000;
    m_sat  = 1'b0;
    m_und  = 1'b0;
    m_ucnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "/dac_out"},    32'(dac_out),    32'(m_dac));
    check({tag, "/running"},    32'(running),    32'(m_run));
    check({tag, "/sat_pulse"},  32'(sat_pulse),  32'(m_sat));
    check({tag, "/underrun"},   32'(underrun),   32'(m_und));
    check({tag, "/fill_level"}, 32'(fill_level), 32'(exp_q.size()));
    check({tag, "/s_ready"},    32'(s_if.s_ready), 32'(exp_q.size() < DEPTH));
`ifdef DAC_UNDERRUN_CNT_EN
    check({tag, "/underrun_cnt"}, 32'(underrun_cnt), 32'(m_ucnt));
`endif
  endtask

  // driver: one clock cycle with the given inputs; model advanced from the rules
  task automatic cycle(input string tag, input logic v, input logic [IW-1:0] d, input logic t);
    int   sz;
    int   val;
    logic do_push;
    logic do_pop;
    logic do_und;
    logic clip;
    logic [DW-1:0] w;
    @(negedge clk);
    s_if.s_valid = v;
    s_if.s_data  = d;
    dac_tick     = t;
    #1;
    sz = exp_q.size();
    check({tag, "/s_ready_pre"}, 32'(s_if.s_ready), 32'(sz < DEPTH));
    do_push = v && (sz < DEPTH);
    do_pop  = m_run && t && (sz > 0);
    do_und  = m_run && t && (sz == 0);
    val  = int'($signed(d));
    clip = 1'b0;
    if (val > 8191) begin
      val = 8191;
      clip = 1'b1;
    end else if (val < -8192) begin
      val = -8192;
      clip = 1'b1;
    end
    w = DW'(val + 8192);
    @(posedge clk);
    #1;
    if (do_pop) m_dac = exp_q.pop_front();
    if (do_push) exp_q.push_back(w);
    m_sat = do_push && clip;
    m_und = do_und;
    if (do_und) begin
      m_run = 1'b0;
      if (m_ucnt < 16'hFFFF) m_ucnt++;
    end else if (!m_run && sz >= PRIME) begin
      m_run = 1'b1;
    end
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst          = 1'b1;
    s_if.s_valid = 1'b0;
    dac_tick     = 1'b0;
    #1;
    model_reset();
    check_outputs({tag, "/in_reset"});
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    dac_tick     = 1'b0;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    model_reset();
    #1;
    check_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: prime with 0..7, then tick them out
    for (int i = 0; i < 8; i++) cycle("t1_push", 1'b1, IW'(i), 1'b0);
    cycle("t1_fsm", 1'b0, '0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle("t1_tick", 1'b0, '0, 1'b1);
      cycle("t1_gap", 1'b0, '0, 1'b0);
    end

    // 2: saturation at both extremes
    do_reset("t2");
    cycle("t2_hi", 1'b1, 18'sh1FFFF, 1'b0);
    cycle("t2_lo", 1'b1, 18'sh20000, 1'b0);
    cycle("t2_edge", 1'b1, 18'sh01FFF, 1'b0);
    cycle("t2_edge", 1'b1, 18'sh3E000, 1'b0);
    cycle("t2_over", 1'b1, 18'sh02000, 1'b0);
    cycle("t2_under", 1'b1, 18'sh3DFFF, 1'b0);
    for (int i = 0; i < 4; i++) cycle("t2_fill", 1'b1, IW'(-i), 1'b0);
    cycle("t2_fsm", 1'b0, '0, 1'b0);
    for (int i = 0; i < 8; i++) cycle("t2_tick", 1'b0, '0, 1'b1);

    // 3: fill to full, 17th sample refused, one tick frees a slot
    do_reset("t3");
    for (int i = 0; i < 16; i++) cycle("t3_fill", 1'b1, IW'(100 + i), 1'b0);
    cycle("t3_full", 1'b1, IW'(999), 1'b0);
    cycle("t3_tick", 1'b1, IW'(999), 1'b1);
    cycle("t3_refill", 1'b1, IW'(999), 1'b0);

    // 4: prime 8, nine ticks -> underrun on the ninth
    do_reset("t4");
    for (int i = 0; i < 8; i++) cycle("t4_push", 1'b1, IW'(200 + i), 1'b0);
    cycle("t4_fsm", 1'b0, '0, 1'b0);
    for (int i = 0; i < 9; i++) cycle("t4_tick", 1'b0, '0, 1'b1);
    cycle("t4_prime_tick", 1'b0, '0, 1'b1);

    // 5: simultaneous push and pop at level 5; push with tick on empty FIFO
    do_reset("t5");
    for (int i = 0; i < 8; i++) cycle("t5_push", 1'b1, IW'(300 + i), 1'b0);
    cycle("t5_fsm", 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("t5_drain", 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) cycle("t5_both", 1'b1, IW'(400 + i), 1'b1);
    for (int i = 0; i < 5; i++) cycle("t5_drain2", 1'b0, '0, 1'b1);
    cycle("t5_empty_both", 1'b1, IW'(-77), 1'b1);
    cycle("t5_after", 1'b0, '0, 1'b0);

    // 6: reset mid-stream at level 10
    do_reset("t6pre");
    for (int i = 0; i < 10; i++) cycle("t6_push", 1'b1, IW'(500 + i), 1'b0);
    do_reset("t6");
    cycle("t6_after", 1'b0, '0, 1'b0);

    // random traffic in phases of differing push/tick density
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 150; i++) begin
        logic          v;
        logic          t;
        logic [IW-1:0] d;
        v = ($urandom_range(0, 3) < ((ph == 1) ? 1 : 3));
        t = ($urandom_range(0, 3) < ((ph == 2) ? 1 : 2));
        if ($urandom_range(0, 1) == 1) d = IW'($urandom);
        else d = IW'(int'($urandom_range(0, 20000)) - 10000);
        cycle("rand", v, d, t);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
